// File: rtl/bmp_byte_parser_if.sv
// Byte-in / pixel-out bus of the BMP byte parser.
//   in_byte/in_valid/in_ready    : raw file bytes, one per handshake
//   pix_out/pix_valid/pix_ready  : decoded {R,G,B} pixels with x/y coordinates
//   img_w/img_h                  : parsed image dimensions
//   hdr_err/frame_end            : sticky status flags
// master = byte source + pixel sink, slave = parser.
interface bmp_byte_parser_if #(
  parameter int COORD_W = 32
);
  logic [7:0]         in_byte;
  logic               in_valid;
  logic               in_ready;
  logic [23:0]        pix_out;
  logic               pix_valid;
  logic               pix_ready;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [COORD_W-1:0] img_w;
  logic [COORD_W-1:0] img_h;
  logic               hdr_err;
  logic               frame_end;

  modport master (
    output in_byte, in_valid, pix_ready,
    input  in_ready, pix_out, pix_valid, x, y, img_w, img_h, hdr_err, frame_end
  );

  modport slave (
    input  in_byte, in_valid, pix_ready,
    output in_ready, pix_out, pix_valid, x, y, img_w, img_h, hdr_err, frame_end
  );
endinterface

// File: rtl/bmp_byte_parser.sv
// Byte-stream decoder for uncompressed 24-bpp bottom-up BMP files.
// Parses the 54-byte header, skips to the pixel-data offset, drops the
// per-row padding and emits one {R,G,B} pixel per handshake with file-order
// x/y coordinates (y = 0 is the first row stored in the file).
// Ports:
//   clk    : single clock, posedge
//   rst    : synchronous active-high reset, clears everything
//   reload : synchronous restart for a new file, keeps img_w/img_h
//   bus    : bmp_byte_parser_if slave (byte input, pixel output, status)
module bmp_byte_parser #(
  parameter int COORD_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                reload,
  bmp_byte_parser_if.slave    bus
);

  typedef enum logic [2:0] {HDR, CHECK, SKIP, PIX, PAD, DONE, ERR} state_t;

  state_t             state, stateNext;
  logic [31:0]        byteCnt;   // header index in HDR, bytes left in SKIP/PAD
  logic [1:0]         phase;     // byte position inside the pixel: B, G, R
  logic [7:0]         bByte, gByte;
  logic [15:0]        sig, bpp;
  logic [31:0]        offset, width, height, compr;
  logic [COORD_W-1:0] nextX, nextY;
  logic [1:0]         lane;
  logic [1:0]         padLen;
  logic               accept, hdrBad, pixDone, rowEnd, lastRow;

  // Every 4-byte header field starts at an index whose low bits are 2'b10,
  // so subtracting 2 from the low bits gives the byte lane inside the field.
  assign lane    = byteCnt[1:0] - 2'd2;
  // 3*w bytes per row: padding to a 4-byte multiple equals w mod 4.
  assign padLen  = bus.img_w[1:0];
  assign accept  = bus.in_valid && bus.in_ready;
  assign pixDone = accept && (state == PIX) && (phase == 2'd2);
  assign rowEnd  = pixDone && (nextX == bus.img_w - COORD_W'(1));
  assign lastRow = (nextY == bus.img_h - COORD_W'(1));
  assign hdrBad  = (sig != 16'h4D42) || (bpp != 16'd24) || (compr != 32'd0) ||
                   (offset < 32'd54) || (width == 32'd0) || (height == 32'd0) ||
                   height[31];

  always_comb begin
    bus.in_ready = 1'b0;
    case (state)
      HDR, SKIP, PAD: bus.in_ready = 1'b1;
      PIX:            bus.in_ready = !bus.pix_valid || bus.pix_ready;
      default:        bus.in_ready = 1'b0;
    endcase
  end

  always_comb begin
    stateNext = state;
    case (state)
      HDR:   if (accept && byteCnt == 32'd53) stateNext = CHECK;
      CHECK: begin
        if (hdrBad)                  stateNext = ERR;
        else if (offset > 32'd54)    stateNext = SKIP;
        else                         stateNext = PIX;
      end
      SKIP:  if (accept && byteCnt == 32'd1) stateNext = PIX;
      PIX: begin
        if (rowEnd) begin
          if (padLen != 2'd0)        stateNext = PAD;
          else if (lastRow)          stateNext = DONE;
        end
      end
      PAD: begin
        // nextY has already advanced past the row that this pad belongs to
        if (accept && byteCnt == 32'd1)
          stateNext = (nextY == bus.img_h) ? DONE : PIX;
      end
      default: stateNext = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || reload) state <= HDR;
    else               state <= stateNext;
  end

  // Byte capture / pixel output register stage
  always_ff @(posedge clk) begin
    if (rst || reload) begin
      byteCnt       <= 32'd0;
      phase         <= 2'd0;
      nextX         <= '0;
      nextY         <= '0;
      bus.pix_out   <= '0;
      bus.pix_valid <= 1'b0;
      bus.x         <= '0;
      bus.y         <= '0;
      bus.hdr_err   <= 1'b0;
      bus.frame_end <= 1'b0;
      if (rst) begin
        bus.img_w <= '0;
        bus.img_h <= '0;
      end
    end else begin
      if (bus.pix_valid && bus.pix_ready) bus.pix_valid <= 1'b0;
      case (state)
        HDR: if (accept) begin
          byteCnt <= byteCnt + 32'd1;
          if (byteCnt < 32'd2)                          sig[{byteCnt[0], 3'b000} +: 8]   <= bus.in_byte;
          else if (byteCnt >= 32'd10 && byteCnt <= 32'd13) offset[{lane, 3'b000} +: 8] <= bus.in_byte;
          else if (byteCnt >= 32'd18 && byteCnt <= 32'd21) width[{lane, 3'b000} +: 8]  <= bus.in_byte;
          else if (byteCnt >= 32'd22 && byteCnt <= 32'd25) height[{lane, 3'b000} +: 8] <= bus.in_byte;
          else if (byteCnt >= 32'd28 && byteCnt <= 32'd29) bpp[{byteCnt[0], 3'b000} +: 8] <= bus.in_byte;
          else if (byteCnt >= 32'd30 && byteCnt <= 32'd33) compr[{lane, 3'b000} +: 8]  <= bus.in_byte;
        end
        CHECK: begin
          byteCnt <= offset - 32'd54;
          if (hdrBad) begin
            bus.hdr_err <= 1'b1;
          end else begin
            bus.img_w <= width[COORD_W-1:0];
            bus.img_h <= height[COORD_W-1:0];
          end
        end
        SKIP, PAD: if (accept) byteCnt <= byteCnt - 32'd1;
        PIX: if (accept) begin
          case (phase)
            2'd0:    bByte <= bus.in_byte;
            2'd1:    gByte <= bus.in_byte;
            default: begin
              bus.pix_out   <= {bus.in_byte, gByte, bByte};
              bus.x         <= nextX;
              bus.y         <= nextY;
              bus.pix_valid <= 1'b1;
            end
          endcase
          phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
          if (rowEnd) begin
            nextX   <= '0;
            nextY   <= nextY + COORD_W'(1);
            byteCnt <= {30'd0, padLen};
          end else if (pixDone) begin
            nextX <= nextX + COORD_W'(1);
          end
        end
        DONE: if (!bus.pix_valid) bus.frame_end <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
